// File: rtl/pdm_playback.sv
// pdm_playback: streams packed 32-bit PDM words from the sample RAM onto the
// audio pin, LSB first, one bit every CLK_DIV clocks, with no gap between words.
// The next word is prefetched into a holding register during the first bit
// period of the current word.
// Optional feature macro: PDM_PLAYBACK_LOOP_EN (wrap to address 0 after
// LAST_ADDR and play until stopped; no done pulse).
module pdm_playback #(
  parameter int CLK_DIV   = 50,
  parameter int LAST_ADDR = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        stop,
  output logic [11:0] ram_rd_addr,
  input  logic [31:0] ram_rd_data,
  output logic        audio_pwm,
  output logic        audio_sd,
  output logic        busy,
  output logic        done
);

  localparam int              DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_MAX   = DW'(CLK_DIV - 1);
  // RAM data for the prefetch address is valid in the second cycle of a word
  localparam logic [DW-1:0]   DIV_CAP   = DW'(1);
  localparam logic [11:0]     ADDR_LAST = 12'(LAST_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    LOAD0  = 2'd2,
    PLAY   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          finish;

  logic [DW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [31:0]   shifter;
  logic [31:0]   holding;
  logic          holding_valid;

  logic          in_play;
  logic          bit_end;
  logic          word_end;
  logic          load_word;
  logic          prefetch_cap;
  logic          end_of_stream;
  logic [11:0]   addr_next;

  assign in_play   = (state == PLAY);
  assign bit_end   = in_play && (div_cnt == DIV_MAX);
  assign word_end  = bit_end && (bit_cnt == 5'd31);
  assign load_word = (state == LOAD0) || word_end;
  assign addr_next = (ram_rd_addr == ADDR_LAST) ? 12'd0 : ram_rd_addr + 12'd1;

`ifdef PDM_PLAYBACK_LOOP_EN
  // Looping never runs out of words, so every word prefetches its successor
  assign end_of_stream = 1'b0;
  assign prefetch_cap  = in_play && (bit_cnt == 5'd0) && (div_cnt == DIV_CAP);
`else
  // Set while the word from LAST_ADDR is playing; nothing follows it
  logic last_word;
  assign end_of_stream = word_end && last_word;
  assign prefetch_cap  = in_play && (bit_cnt == 5'd0) && (div_cnt == DIV_CAP) && !last_word;
`endif

  assign busy      = (state != IDLE);
  assign audio_sd  = busy;
  assign audio_pwm = in_play && shifter[0];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; stop wins over everything while busy
  always_comb begin
    state_nx = state;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (play && !stop) begin
          state_nx = FETCH0;
        end
      end
      FETCH0: begin
        state_nx = stop ? IDLE : LOAD0;
      end
      LOAD0: begin
        state_nx = stop ? IDLE : PLAY;
      end
      PLAY: begin
        if (stop) begin
          state_nx = IDLE;
        end else if (end_of_stream) begin
          state_nx = IDLE;
          finish   = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Bit timing, shifter, prefetch and address datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rd_addr   <= 12'd0;
      done          <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= 5'd0;
      shifter       <= 32'd0;
      holding       <= 32'd0;
      holding_valid <= 1'b0;
`ifndef PDM_PLAYBACK_LOOP_EN
      last_word     <= 1'b0;
`endif
    end else begin
      done <= finish;

      if (prefetch_cap) begin
        holding       <= ram_rd_data;
        holding_valid <= 1'b1;
      end

      if (in_play) begin
        if (bit_end) begin
          div_cnt <= '0;
          bit_cnt <= bit_cnt + 5'd1;
          if (!word_end) begin
            shifter <= shifter >> 1;
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end

      // The word being loaded always comes from the current ram_rd_addr,
      // so that address decides whether this is the final word.
      if (load_word) begin
        shifter       <= (state == LOAD0) ? ram_rd_data
                                          : (holding_valid ? holding : 32'd0);
        holding_valid <= 1'b0;
`ifdef PDM_PLAYBACK_LOOP_EN
        ram_rd_addr   <= addr_next;
`else
        last_word     <= (ram_rd_addr == ADDR_LAST);
        if (ram_rd_addr != ADDR_LAST) begin
          ram_rd_addr <= addr_next;
        end
`endif
      end

      // Leaving or sitting in IDLE: park the address at 0, drop prefetch
      if (state_nx == IDLE) begin
        ram_rd_addr   <= 12'd0;
        holding_valid <= 1'b0;
        div_cnt       <= '0;
        bit_cnt       <= 5'd0;
`ifndef PDM_PLAYBACK_LOOP_EN
        last_word     <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pdm_playback.sv
// tb_pdm_playback: randomized playback scenarios against a timeline model.
// The model knows only "t cycles since play was accepted" and derives every
// output from the RAM contents with plain arithmetic.
module tb_pdm_playback;

  localparam int D = 4;
`ifdef PDM_PLAYBACK_LOOP_EN
  localparam int LAST = 1;
  localparam bit LOOP = 1'b1;
`else
  localparam int LAST = 3;
  localparam bit LOOP = 1'b0;
`endif
  localparam int N     = LAST + 1;
  localparam int TOTAL = 2 + 32 * D * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] ram_rd_addr;
  logic [31:0] ram_rd_data = 32'd0;
  logic        audio_pwm;
  logic        audio_sd;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:4095];

  int n_tests = 0;
  int n_fail  = 0;

  pdm_playback #(.CLK_DIV(D), .LAST_ADDR(LAST)) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .stop       (stop),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .audio_pwm  (audio_pwm),
    .audio_sd   (audio_sd),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rd_data <= mem[ram_rd_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected vector: {addr_check_en, addr[11:0], busy, audio_sd, audio_pwm, done}
  logic [16:0] exp_q[$];
  int          mt = 0;

  function automatic int model_next(input int t, input logic p, input logic s);
    if (t > 0) begin
      if (s) return 0;
      if (!LOOP && t == TOTAL) return 0;
      return t + 1;
    end
    return (p && !s) ? 1 : 0;
  endfunction

  function automatic logic model_done(input int t, input logic s);
    return (t > 0) && !s && !LOOP && (t == TOTAL);
  endfunction

  function automatic logic [16:0] make_exp(input int t, input logic dn);
    int          k;
    int          w;
    int          b;
    logic        aen;
    logic [11:0] a;
    logic        pwm;
    if (t == 0) return {1'b1, 12'd0, 3'b000, dn};
    aen = 1'b0;
    a   = 12'd0;
    pwm = 1'b0;
    if (t < 3) begin
      aen = 1'b1;
    end else begin
      k   = (t - 3) / D;
      w   = (k / 32) % N;
      b   = k % 32;
      pwm = mem[w][b];
      if (k % 32 == 0) begin
        if (LOOP) begin
          aen = 1'b1;
          a   = 12'((w + 1) % N);
        end else if (w < N - 1) begin
          aen = 1'b1;
          a   = 12'(w + 1);
        end
      end
    end
    return {aen, a, 1'b1, 1'b1, pwm, 1'b0};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mt <= 0;
      exp_q.delete();
    end else begin
      mt <= model_next(mt, play, stop);
      exp_q.push_back(make_exp(model_next(mt, play, stop), model_done(mt, stop)));
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic compare_cycle(input logic [16:0] e);
    check("outputs_busy_sd_pwm_done", 32'({busy, audio_sd, audio_pwm, done}), 32'(e[3:0]));
    if (e[16]) check("ram_rd_addr", 32'(ram_rd_addr), 32'(e[15:4]));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) check("model_queue_nonempty", 32'd0, 32'd1);
      else compare_cycle(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = $urandom();
  endtask

  // Pulses play, then samples every cycle (cycle 1 = first cycle after the
  // accepting edge) until busy drops. stop/replay/rst can be injected at a
  // given cycle (0 = never).
  task automatic play_and_wait(input int stop_at, input int replay_at, input int rst_at,
                               output int busy_cyc, output int done_cnt,
                               output int first_bit, output int fall_cyc);
    bit ended;
    busy_cyc  = 0;
    done_cnt  = 0;
    first_bit = -1;
    fall_cyc  = -1;
    ended     = 1'b0;
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    for (int cyc = 1; cyc <= 4 * TOTAL + 100; cyc++) begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (audio_pwm && first_bit < 0) first_bit = cyc;
      if (!audio_pwm && first_bit >= 0 && fall_cyc < 0) fall_cyc = cyc;
      if (stop_at > 0 && cyc == stop_at + 1)
        check("abort_outputs", 32'({busy, audio_sd, audio_pwm, done}), 32'd0);
      if (!busy) begin
        ended = 1'b1;
        break;
      end
      if (cyc == rst_at) begin
        #1 rst = 1'b1;
        #1 check("rst_mid_outputs", 32'({ram_rd_addr, audio_pwm, audio_sd, busy, done}), 32'd0);
        play = 1'b0;
        stop = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        ended = 1'b1;
        break;
      end
      play = (cyc == replay_at);
      stop = (cyc == stop_at);
      @(negedge clk);
    end
    play = 1'b0;
    stop = 1'b0;
    if (!ended) check("playback_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int bc, dc, fb, fc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ram_rd_addr, audio_pwm, audio_sd, busy, done}), 32'd0);
    #1 rst = 1'b0;
    idle(3);

`ifdef PDM_PLAYBACK_LOOP_EN
    // Loop: three full passes plus part of a fourth, ended only by stop
    mem[0] = 32'hA5A5A5A5;
    mem[1] = 32'h0F0F00FF;
    play_and_wait(2 + 32 * D * N * 3 + 17, 0, 0, bc, dc, fb, fc);
    check("loop_busy_cycles", 32'(bc), 32'd787);
    check("loop_done_count", 32'(dc), 32'd0);
    idle(4);
    fill_random();
    play_and_wait(2 + 32 * D * N * 4 + 5, 300, 0, bc, dc, fb, fc);
    check("loop2_done_count", 32'(dc), 32'd0);
    idle(4);
`else
    // Basic pass
    mem[0] = 32'hA5A5A5A5;
    mem[1] = 32'hFFFF0000;
    mem[2] = 32'h00000001;
    mem[3] = 32'h80000000;
    play_and_wait(0, 0, 0, bc, dc, fb, fc);
    check("basic_busy_cycles", 32'(bc), 32'd514);
    check("basic_done_count", 32'(dc), 32'd1);
    check("basic_first_bit_cycle", 32'(fb), 32'd3);
    idle(5);

    // Seamless word boundary: 1->0 exactly 32*D cycles after the first bit
    fill_random();
    mem[0] = 32'hFFFFFFFF;
    mem[1] = 32'h00000000;
    play_and_wait(0, 0, 0, bc, dc, fb, fc);
    check("seam_first_bit_cycle", 32'(fb), 32'd3);
    check("seam_fall_minus_first", 32'(fc - fb), 32'd128);
    check("seam_busy_cycles", 32'(bc), 32'd514);
    idle(3);

    // Abort 50 cycles in, then a fresh play restarts from address 0
    fill_random();
    play_and_wait(50, 0, 0, bc, dc, fb, fc);
    check("abort_busy_cycles", 32'(bc), 32'd50);
    check("abort_done_count", 32'(dc), 32'd0);
    idle(6);
    play_and_wait(0, 0, 0, bc, dc, fb, fc);
    check("restart_busy_cycles", 32'(bc), 32'd514);
    check("restart_done_count", 32'(dc), 32'd1);
    idle(2);

    // play while busy is ignored
    fill_random();
    play_and_wait(0, 100, 0, bc, dc, fb, fc);
    check("replay_busy_cycles", 32'(bc), 32'd514);
    check("replay_done_count", 32'(dc), 32'd1);
    idle(2);

    // play and stop together in IDLE
    @(negedge clk);
    play = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    play = 1'b0;
    stop = 1'b0;
    check("play_stop_idle_busy", 32'(busy), 32'd0);
    idle(3);

    // Reset during word 1, then stay idle until the next play
    fill_random();
    play_and_wait(0, 0, 3 + 32 * D + 10, bc, dc, fb, fc);
    check("rst_mid_done_count", 32'(dc), 32'd0);
    idle(10);
    check("post_rst_idle_busy", 32'(busy), 32'd0);
    play_and_wait(0, 0, 0, bc, dc, fb, fc);
    check("post_rst_busy_cycles", 32'(bc), 32'd514);

    // Randomized passes, some aborted at a random point
    for (int r = 0; r < 6; r++) begin
      int sa;
      fill_random();
      sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 500)) : 0;
      play_and_wait(sa, int'($urandom_range(0, 400)), 0, bc, dc, fb, fc);
      check("rand_busy_cycles", 32'(bc), 32'((sa > 0) ? sa : 514));
      check("rand_done_count", 32'(dc), 32'((sa > 0) ? 0 : 1));
      idle(int'($urandom_range(1, 8)));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
